// File: rtl/glitch_pkg.sv
// Shared types and default widths for the clock-glitch controller.
package glitch_pkg;
    localparam int CNT_W = 16;
    localparam int REP_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_GLITCH,
        S_GAP
    } glitch_state_e;
endpackage

// File: rtl/glitch_down_counter.sv
// Loadable down-counter that saturates at zero; term_o flags the last count.
module glitch_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q <= W'(1));
endmodule

// File: rtl/glitch_clk_ctrl.sv
// Trigger-driven clock-glitch controller: removes whole clk pulses at a
// programmed offset after a trigger rising edge.
module glitch_clk_ctrl #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trigger_i,
    input  logic [CNT_W-1:0] cfg_delay_i,
    input  logic [CNT_W-1:0] cfg_width_i,
    input  logic [CNT_W-1:0] cfg_gap_i,
    input  logic [REP_W-1:0] cfg_repeat_i,
    output logic             armed_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             glitch_active_o,
    output logic             clk_glitch_o
);
    import glitch_pkg::*;

    glitch_state_e    state_q, state_d;
    logic             trig_q, done_q, done_d, mask_q, cfg_load;
    logic [CNT_W-1:0] delay_q, width_q, gap_q;
    logic [REP_W-1:0] repeat_q;
    logic [CNT_W-1:0] width_eff, dg_val, dg_cnt, w_cnt;
    logic [REP_W-1:0] repeat_eff, r_cnt;
    logic             dg_load, dg_dec, dg_term;
    logic             w_load, w_dec, w_term;
    logic             r_load, r_dec, r_term;
    logic             trig_rise;

    assign width_eff  = (width_q  == '0) ? CNT_W'(1) : width_q;
    assign repeat_eff = (repeat_q == '0) ? REP_W'(1) : repeat_q;
    assign trig_rise  = trigger_i & ~trig_q;

    always_comb begin
        state_d  = state_q;
        cfg_load = 1'b0;
        done_d   = 1'b0;
        dg_load  = 1'b0;
        dg_val   = delay_q;
        dg_dec   = 1'b0;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        r_load   = 1'b0;
        r_dec    = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (arm_i) begin
                    cfg_load = 1'b1;
                    state_d  = S_ARMED;
                end
                S_ARMED: if (trig_rise) begin
                    r_load = 1'b1;
                    if (delay_q == '0) begin
                        w_load  = 1'b1;
                        state_d = S_GLITCH;
                    end else begin
                        dg_load = 1'b1;
                        state_d = S_DELAY;
                    end
                end
                S_DELAY, S_GAP: begin
                    if (dg_term) begin
                        w_load  = 1'b1;
                        state_d = S_GLITCH;
                    end else begin
                        dg_dec = 1'b1;
                    end
                end
                S_GLITCH: begin
                    if (!w_term) begin
                        w_dec = 1'b1;
                    end else if (r_term) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        r_dec = 1'b1;
                        // zero gap chains windows back to back
                        if (gap_q == '0) begin
                            w_load  = 1'b1;
                            state_d = S_GLITCH;
                        end else begin
                            dg_load = 1'b1;
                            dg_val  = gap_q;
                            state_d = S_GAP;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
            delay_q  <= '0;
            width_q  <= '0;
            gap_q    <= '0;
            repeat_q <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= trigger_i;
            done_q  <= done_d;
            if (cfg_load) begin
                delay_q  <= cfg_delay_i;
                width_q  <= cfg_width_i;
                gap_q    <= cfg_gap_i;
                repeat_q <= cfg_repeat_i;
            end
        end
    end

    glitch_down_counter #(.W(CNT_W)) u_dg_cnt (
        .clk(clk), .rst_n(rst_n), .load_i(dg_load), .load_val_i(dg_val),
        .dec_i(dg_dec), .cnt_o(dg_cnt), .term_o(dg_term)
    );

    glitch_down_counter #(.W(CNT_W)) u_w_cnt (
        .clk(clk), .rst_n(rst_n), .load_i(w_load), .load_val_i(width_eff),
        .dec_i(w_dec), .cnt_o(w_cnt), .term_o(w_term)
    );

    glitch_down_counter #(.W(REP_W)) u_r_cnt (
        .clk(clk), .rst_n(rst_n), .load_i(r_load), .load_val_i(repeat_eff),
        .dec_i(r_dec), .cnt_o(r_cnt), .term_o(r_term)
    );

    assign armed_o         = (state_q == S_ARMED);
    assign busy_o          = (state_q == S_DELAY) || (state_q == S_GLITCH) || (state_q == S_GAP);
    assign glitch_active_o = (state_q == S_GLITCH);
    assign done_o          = done_q;

    // Mask changes only while clk is low, so no partial high phase escapes.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= 1'b0;
        else        mask_q <= glitch_active_o;
    end

    assign clk_glitch_o = clk & ~mask_q;
endmodule

// File: tb/tb_glitch_clk_ctrl.sv
// Scoreboard bench: stimulus pushes expected glitch records, monitor checks them on done_o.
module tb_glitch_clk_ctrl;
    localparam int CNT_W = 16;
    localparam int REP_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             arm_i = 1'b0, abort_i = 1'b0, trigger_i = 1'b0;
    logic [CNT_W-1:0] cfg_delay_i = '0, cfg_width_i = '0, cfg_gap_i = '0;
    logic [REP_W-1:0] cfg_repeat_i = '0;
    logic             armed_o, busy_o, done_o, glitch_active_o, clk_glitch_o;

    glitch_clk_ctrl #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .abort_i(abort_i), .trigger_i(trigger_i),
        .cfg_delay_i(cfg_delay_i), .cfg_width_i(cfg_width_i), .cfg_gap_i(cfg_gap_i),
        .cfg_repeat_i(cfg_repeat_i), .armed_o(armed_o), .busy_o(busy_o), .done_o(done_o),
        .glitch_active_o(glitch_active_o), .clk_glitch_o(clk_glitch_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int done_cyc;
        int first_g;
        int g_cyc;
        int g_rise;
        int supp;
        int first_supp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0;
    int   g_cyc = 0, g_rise = 0, g_first = 0, s_cnt = 0, s_first = 0;
    logic prev_ga = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_acc();
        g_cyc = 0; g_rise = 0; g_first = 0; s_cnt = 0; s_first = 0;
    endtask

    // Monitor: accumulates observed glitch activity, checks against the scoreboard on done_o.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (glitch_active_o) begin
            if (!prev_ga) begin
                g_rise++;
                if (g_rise == 1) g_first = cyc;
            end
            g_cyc++;
        end
        prev_ga = glitch_active_o;
        if (!clk_glitch_o) begin
            if (s_cnt == 0) s_first = cyc;
            s_cnt++;
        end
        if (done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("first_glitch_cycle", g_first, e.first_g);
                chk("glitch_cycles", g_cyc, e.g_cyc);
                chk("glitch_windows", g_rise, e.g_rise);
                chk("suppressed_pulses", s_cnt, e.supp);
                chk("first_suppressed", s_first, e.first_supp);
            end
            clr_acc();
        end
    end

    task automatic wait_to(input int c);
        do begin
            @(posedge clk); #1;
        end while (cyc < c);
    endtask

    task automatic arm(input int d, input int w, input int g, input int r);
        @(posedge clk); #1;
        cfg_delay_i = CNT_W'(d); cfg_width_i = CNT_W'(w);
        cfg_gap_i = CNT_W'(g); cfg_repeat_i = REP_W'(r);
        arm_i = 1'b1;
        @(posedge clk); #1;
        arm_i = 1'b0;
        chk("armed_after_arm", armed_o, 1);
    endtask

    // Raises trigger so it is sampled at posedge T; returns at T+#1 with trigger low.
    task automatic trig(output int t);
        @(posedge clk); #1;
        trigger_i = 1'b1;
        t = cyc + 1;
        @(posedge clk); #1;
        trigger_i = 1'b0;
    endtask

    task automatic push(input int dc, input int fg, input int gc, input int gr, input int sp, input int fs);
        exp_t e;
        e.done_cyc = dc; e.first_g = fg; e.g_cyc = gc; e.g_rise = gr; e.supp = sp; e.first_supp = fs;
        sb.push_back(e);
    endtask

    initial begin
        int t;
        // reset state
        @(posedge clk); #1;
        chk("reset_outputs", {armed_o, busy_o, done_o, glitch_active_o}, 0);
        chk("reset_clk_follows", clk_glitch_o, 1);
        @(negedge clk); #1 rst_n = 1'b1;
        clr_acc();

        // delay 5, width 1; config changes and retrigger mid-sequence ignored
        arm(5, 1, 0, 1);
        clr_acc();
        trig(t);
        push(t + 6, t + 5, 1, 1, 1, t + 6);
        cfg_delay_i = 1; cfg_width_i = 7; cfg_repeat_i = 4;
        chk("busy_in_delay", busy_o, 1);
        chk("not_armed_in_delay", armed_o, 0);
        trigger_i = 1'b1;
        wait_to(t + 2);
        trigger_i = 1'b0;
        wait_to(t + 12);
        chk("sb_drained_1", sb.size(), 0);

        // delay 0, width 3, repeat 2, gap 2
        arm(0, 3, 2, 2);
        clr_acc();
        trig(t);
        push(t + 8, t, 6, 2, 6, t + 1);
        wait_to(t + 14);
        chk("sb_drained_2", sb.size(), 0);

        // gap 0 -> one contiguous 6-cycle window; arm while busy ignored
        arm(2, 2, 0, 3);
        clr_acc();
        trig(t);
        push(t + 8, t + 2, 6, 1, 6, t + 3);
        cfg_delay_i = 0; cfg_width_i = 1; cfg_repeat_i = 1;
        arm_i = 1'b1;
        wait_to(t + 1);
        arm_i = 1'b0;
        wait_to(t + 14);
        chk("sb_drained_3", sb.size(), 0);
        chk("idle_after_3", {armed_o, busy_o}, 0);

        // trigger already high at arm: no fire until a fresh edge; width 0 / repeat 0 act as 1
        @(posedge clk); #1 trigger_i = 1'b1;
        arm(3, 0, 0, 0);
        clr_acc();
        wait_to(cyc + 20);
        chk("held_trig_no_glitch", g_cyc, 0);
        chk("held_trig_no_supp", s_cnt, 0);
        chk("held_trig_still_armed", armed_o, 1);
        trigger_i = 1'b0;
        trig(t);
        push(t + 4, t + 3, 1, 1, 1, t + 4);
        wait_to(t + 10);
        chk("sb_drained_4", sb.size(), 0);

        // abort in the 4th glitch cycle of a 10-wide window
        arm(0, 10, 0, 1);
        clr_acc();
        trig(t);
        wait_to(t + 3);
        abort_i = 1'b1;
        wait_to(t + 4);
        abort_i = 1'b0;
        chk("abort_glitch_drop", glitch_active_o, 0);
        chk("abort_not_armed", armed_o, 0);
        wait_to(t + 16);
        chk("abort_glitch_cycles", g_cyc, 4);
        chk("abort_supp_pulses", s_cnt, 4);
        chk("abort_idle", {armed_o, busy_o}, 0);
        chk("sb_drained_5", sb.size(), 0);

        // async reset mid-DELAY; trigger afterwards without re-arm does nothing
        arm(20, 2, 0, 1);
        clr_acc();
        trig(t);
        wait_to(t + 4);
        #3 rst_n = 1'b0;
        #1 chk("rst_delay_outputs", {armed_o, busy_o, done_o, glitch_active_o}, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        clr_acc();
        trig(t);
        wait_to(t + 30);
        chk("rst_no_rearm_glitch", g_cyc, 0);
        chk("rst_no_rearm_busy", {armed_o, busy_o}, 0);

        // async reset mid-window during clk low: next high phase passes
        arm(0, 10, 0, 1);
        clr_acc();
        trig(t);
        wait_to(t + 3);
        @(negedge clk); #1 rst_n = 1'b0;
        #1 chk("rst_win_outputs", {busy_o, glitch_active_o}, 0);
        @(posedge clk); #1;
        chk("rst_win_clk_resumes", clk_glitch_o, 1);
        chk("rst_win_supp_before", s_cnt, 3);
        @(negedge clk); #1 rst_n = 1'b1;
        wait_to(cyc + 5);
        chk("sb_drained_6", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
